// File: rtl/tempo_sequencer.sv
// tempo_sequencer: pattern-driven drum step sequencer
// tempo prescaler, idle/run/pause transport, voice rows
module tempo_sequencer #(
   parameter int STEPS  = 16,
   parameter int VOICES = 4,
   parameter int DIVW   = 24
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       stop,
   input  logic                       pause,
   input  logic [DIVW-1:0]            tempo_lim,
   input  logic                       tempo_load,
   input  logic [$clog2(STEPS):0]     len,
   input  logic                       pat_we,
   input  logic [$clog2(VOICES)-1:0]  pat_voice,
   input  logic [STEPS-1:0]           pat_data,
   output logic                       step_tick,
   output logic [$clog2(STEPS)-1:0]   step_idx,
   output logic [VOICES-1:0]          trig,
   output logic                       bar_start,
   output logic                       playing,
   output logic                       paused
);

   localparam int SW = $clog2(STEPS);
   localparam int LW = SW + 1;
   localparam int VW = $clog2(VOICES);
   localparam int NR = 1 << VW;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   state_t state, state_nx;

   logic [DIVW-1:0]   q;
   logic [DIVW-1:0]   shadow;
   logic [DIVW-1:0]   lim_act;
   logic [DIVW-1:0]   lim_src;
   logic [STEPS-1:0]  pat [VOICES];
   logic [NR-1:0]     row_ok;
   logic [LW-1:0]     eff_len;
   logic [SW-1:0]     step_nx;
   logic [SW-1:0]     sel;
   logic [VOICES-1:0] col;
   logic              go;
   logic              cnt;
   logic              wrap;

   // transport state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // next state: stop beats pause beats start
   always_comb begin
      state_nx = state;
      priority case (1'b1)
         stop:                     state_nx = IDLE;
         (state == RUN) && pause:  state_nx = PAUSE;
         (state != RUN) && start:  state_nx = RUN;
         default: ;
      endcase
   end

   // edge qualifiers, next step and trigger column
   always_comb begin
      go      = (state == IDLE) && (state_nx == RUN);
      cnt     = (state != IDLE) && (state_nx == RUN);
      wrap    = cnt && (q >= lim_act);
      lim_src = tempo_load ? tempo_lim : shadow;
      eff_len = ((len == '0) || (len > LW'(STEPS))) ?
                LW'(STEPS) : len;
      step_nx = ({1'b0, step_idx} >= eff_len - LW'(1)) ?
                '0 : step_idx + SW'(1);
      sel     = go ? '0 : step_nx;
      col     = '0;
      for (int v = 0; v < VOICES; v++) col[v] = pat[v][sel];
   end

   for (genvar i = 0; i < NR; i++) begin : g_ok
      assign row_ok[i] = (i < VOICES);
   end

   // prescaler, step counter and registered tick/trig
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q         <= '0;
         step_idx  <= '0;
         step_tick <= 1'b0;
         trig      <= '0;
      end else begin
         step_tick <= 1'b0;
         trig      <= '0;
         if (state_nx == IDLE) begin
            q        <= '0;
            step_idx <= '0;
         end else if (go) begin
            q         <= '0;
            step_idx  <= '0;
            step_tick <= 1'b1;
            trig      <= col;
         end else if (wrap) begin
            q         <= '0;
            step_idx  <= step_nx;
            step_tick <= 1'b1;
            trig      <= col;
         end else if (cnt) begin
            q <= q + DIVW'(1);
         end
      end
   end

   // tempo shadow; active limit moves only on a period boundary while running
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow  <= '0;
         lim_act <= '0;
      end else begin
         if (tempo_load) shadow <= tempo_lim;
         if ((state != RUN) || wrap) lim_act <= lim_src;
      end
   end

   // pattern rows, whole-row writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int v = 0; v < VOICES; v++) pat[v] <= '0;
      end else if (pat_we && row_ok[pat_voice]) begin
         pat[pat_voice] <= pat_data;
      end
   end

   assign bar_start = step_tick && (step_idx == '0);
   assign playing   = (state == RUN);
   assign paused    = (state == PAUSE);

endmodule

// File: tb/tb_tempo_sequencer.sv
// tb_tempo_sequencer: directed and random checks
// against a cycle-level behavioural model
module tb_tempo_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, stop, pause;
   logic [23:0] tempo_lim;
   logic        tempo_load;
   logic [4:0]  len;
   logic        pat_we;
   logic [1:0]  pat_voice;
   logic [15:0] pat_data;
   logic        step_tick;
   logic [3:0]  step_idx;
   logic [3:0]  trig;
   logic        bar_start, playing, paused;

   tempo_sequencer #(.STEPS(16), .VOICES(4), .DIVW(24)) dut (
      .clk(clk), .rst(rst),
      .start(start), .stop(stop), .pause(pause),
      .tempo_lim(tempo_lim), .tempo_load(tempo_load),
      .len(len),
      .pat_we(pat_we), .pat_voice(pat_voice),
      .pat_data(pat_data),
      .step_tick(step_tick), .step_idx(step_idx),
      .trig(trig), .bar_start(bar_start),
      .playing(playing), .paused(paused)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int t0 = 0;

   int       tq_rel[$];
   int       tq_idx[$];
   bit [3:0] tq_trig[$];
   bit       tq_bar[$];

   // model: 0 idle, 1 run, 2 pause
   int       m_mode, m_q, m_step, m_lim, m_shadow;
   bit [15:0] m_pat[4];
   bit       m_tick;
   bit [3:0] m_trig;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic int eff(input int l);
      return (l == 0 || l > 16) ? 16 : l;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_q = 0; m_step = 0;
      m_lim = 0; m_shadow = 0;
      m_tick = 0; m_trig = '0;
      for (int v = 0; v < 4; v++) m_pat[v] = '0;
   endtask

   task automatic fire();
      m_tick = 1;
      for (int v = 0; v < 4; v++) m_trig[v] = m_pat[v][m_step];
   endtask

   // one clock edge of the sequencer, stated as transport rules
   task automatic model_edge();
      int  lsrc;
      int  prev;
      bit  wrapped;
      prev    = m_mode;
      wrapped = 0;
      lsrc    = tempo_load ? int'(tempo_lim) : m_shadow;
      if (tempo_load) m_shadow = int'(tempo_lim);
      m_tick = 0;
      m_trig = '0;
      if (stop) begin
         m_mode = 0; m_q = 0; m_step = 0;
      end else if (m_mode == 0) begin
         if (start) begin
            m_mode = 1; m_q = 0; m_step = 0;
            fire();
         end
      end else if (m_mode == 1 && pause) begin
         m_mode = 2;
      end else if (m_mode == 2 && !start) begin
         m_mode = 2;
      end else begin
         m_mode = 1;
         if (m_q >= m_lim) begin
            m_q = 0;
            m_step = (m_step + 1 >= eff(int'(len))) ? 0 : m_step + 1;
            fire();
            wrapped = 1;
         end else begin
            m_q++;
         end
      end
      if (prev != 1 || wrapped) m_lim = lsrc;
      if (pat_we) m_pat[pat_voice] = pat_data;
   endtask

   task automatic clk_cycle();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      chk("tick", step_tick, m_tick);
      chk("idx", step_idx, m_step);
      chk("trig", trig, m_trig);
      chk("bar", bar_start, m_tick && m_step == 0);
      chk("play", playing, m_mode == 1);
      chk("paused", paused, m_mode == 2);
      if (step_tick) begin
         tq_rel.push_back(cyc - t0);
         tq_idx.push_back(int'(step_idx));
         tq_trig.push_back(trig);
         tq_bar.push_back(bar_start);
      end
      start = 0; stop = 0; pause = 0;
      tempo_load = 0; pat_we = 0;
   endtask

   task automatic mark();
      t0 = cyc;
      tq_rel.delete(); tq_idx.delete();
      tq_trig.delete(); tq_bar.delete();
   endtask

   task automatic load_lim(input int l);
      tempo_lim = 24'(l);
      tempo_load = 1;
      clk_cycle();
   endtask

   task automatic do_reset();
      rst = 0;
      start = 0; stop = 0; pause = 0;
      tempo_lim = '0; tempo_load = 0; len = '0;
      pat_we = 0; pat_voice = '0; pat_data = '0;
      #2;
      model_reset();
      chk("rst_tick", step_tick, 0);
      chk("rst_idx", step_idx, 0);
      chk("rst_trig", trig, 0);
      chk("rst_bar", bar_start, 0);
      chk("rst_play", playing, 0);
      chk("rst_paused", paused, 0);
      @(posedge clk);
      #1;
      rst = 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int exp_rel[5];
      int nb, hits, r;
      rst = 0;
      do_reset();

      // T1: lim 3 -> ticks at 1,5,9,13
      load_lim(3);
      mark();
      start = 1;
      clk_cycle();
      repeat (13) clk_cycle();
      chk("t1_n", tq_rel.size(), 4);
      exp_rel = '{1, 5, 9, 13, 0};
      for (int i = 0; i < 4 && i < tq_rel.size(); i++) begin
         chk("t1_rel", tq_rel[i], exp_rel[i]);
         chk("t1_idx", tq_idx[i], i);
      end
      nb = 0;
      foreach (tq_bar[i]) nb += int'(tq_bar[i]);
      chk("t1_bars", nb, 1);
      if (tq_bar.size() > 0) chk("t1_bar0", tq_bar[0], 1);

      // T2: row0=0101, len 8, lim 0
      do_reset();
      pat_we = 1; pat_voice = 0; pat_data = 16'h0101;
      len = 5'd8;
      load_lim(0);
      mark();
      start = 1;
      clk_cycle();
      repeat (19) clk_cycle();
      chk("t2_n", tq_rel.size(), 20);
      hits = 0;
      for (int i = 0; i < tq_trig.size(); i++) begin
         hits += int'(tq_trig[i][0]);
         chk("t2_trig0", tq_trig[i][0], (i % 8) == 0);
      end
      chk("t2_hits", hits, 3);
      if (tq_idx.size() > 8) begin
         chk("t2_idx7", tq_idx[7], 7);
         chk("t2_wrap", tq_idx[8], 0);
      end
      len = '0;

      // T3: lim 9, pause at q=4, resume
      do_reset();
      load_lim(9);
      mark();
      start = 1;
      clk_cycle();
      repeat (4) clk_cycle();
      pause = 1;
      clk_cycle();
      chk("t3_paused", paused, 1);
      repeat (20) clk_cycle();
      chk("t3_idx_hold", step_idx, 0);
      r = cyc - t0 + 1;
      start = 1;
      clk_cycle();
      repeat (8) clk_cycle();
      chk("t3_n", tq_rel.size(), 2);
      if (tq_rel.size() > 1) begin
         chk("t3_gap", tq_rel[1] - r, 5);
         chk("t3_idx", tq_idx[1], 1);
      end

      // T4: lim 3, load 7 mid-period
      do_reset();
      load_lim(3);
      mark();
      start = 1;
      clk_cycle();
      repeat (5) clk_cycle();
      tempo_lim = 24'd7;
      tempo_load = 1;
      clk_cycle();
      repeat (19) clk_cycle();
      exp_rel = '{1, 5, 9, 17, 25};
      chk("t4_n", tq_rel.size(), 5);
      for (int i = 0; i < 5 && i < tq_rel.size(); i++)
         chk("t4_rel", tq_rel[i], exp_rel[i]);

      // T5: start+stop+pause on a due tick
      do_reset();
      load_lim(3);
      mark();
      start = 1;
      clk_cycle();
      repeat (7) clk_cycle();
      start = 1; stop = 1; pause = 1;
      clk_cycle();
      chk("t5_play", playing, 0);
      chk("t5_paused", paused, 0);
      chk("t5_idx", step_idx, 0);
      chk("t5_tick", step_tick, 0);
      repeat (6) clk_cycle();
      chk("t5_n", tq_rel.size(), 2);

      // T5b: asynchronous reset mid-run
      pat_we = 1; pat_voice = 0; pat_data = 16'hffff;
      load_lim(0);
      mark();
      start = 1;
      clk_cycle();
      repeat (2) clk_cycle();
      chk("t5_pre", step_tick, 1);
      #2;
      rst = 0;
      #1;
      chk("t5_async_tick", step_tick, 0);
      chk("t5_async_trig", trig, 0);
      chk("t5_async_idx", step_idx, 0);
      chk("t5_async_play", playing, 0);
      chk("t5_async_bar", bar_start, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1;
      mark();
      repeat (6) clk_cycle();
      chk("t5_no_tick", tq_rel.size(), 0);

      // T6: row write on the edge that emits step 2
      do_reset();
      load_lim(0);
      mark();
      start = 1;
      clk_cycle();
      clk_cycle();
      pat_we = 1; pat_voice = 1; pat_data = 16'h0004;
      clk_cycle();
      repeat (17) clk_cycle();
      chk("t6_n", tq_rel.size(), 20);
      if (tq_trig.size() > 18) begin
         chk("t6_idx", tq_idx[2], 2);
         chk("t6_old", tq_trig[2][1], 0);
         chk("t6_new", tq_trig[18][1], 1);
      end

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         start      = ($urandom % 12) == 0;
         stop       = ($urandom % 60) == 0;
         pause      = ($urandom % 25) == 0;
         tempo_load = ($urandom % 20) == 0;
         tempo_lim  = 24'($urandom % 6);
         if (($urandom % 40) == 0) len = 5'($urandom % 21);
         pat_we     = ($urandom % 8) == 0;
         pat_voice  = 2'($urandom % 4);
         pat_data   = 16'($urandom);
         clk_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
